// File: rtl/scroll_colour_gen_pkg.sv
// Shared mode encodings and width helper for the scrolling colour generator.
package scroll_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_RR    = 2'd1,
    MODE_WALK  = 2'd2,
    MODE_HOLD  = 2'd3
  } mode_e;

  function automatic int unsigned calc_w(input int unsigned ch_bits,
                                         input int unsigned num_ch);
    return ch_bits * num_ch;
  endfunction

endpackage

// File: rtl/scroll_colour_gen_prescaler.sv
// Scroll-rate prescaler: emits a step whenever the counter reaches the programmed period.
module scroll_prescaler #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             pixel_clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] rate,
  output logic             step
);

  logic [DIV_W-1:0] r_cnt;
  logic             w_due;

  // >= so that lowering rate below the running count forces an immediate step
  assign w_due = (r_cnt >= rate);
  assign step  = enable & ~clear & w_due;

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      r_cnt <= DIV_W'(0);
    end else if (clear) begin
      r_cnt <= DIV_W'(0);
    end else if (enable) begin
      r_cnt <= w_due ? DIV_W'(0) : r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/scroll_colour_gen.sv
// Scrolling colour word generator with count, round-robin, walking-one and hold modes.
module scroll_colour_gen
  import scroll_pkg::*;
#(
  parameter int unsigned CH_BITS = 3,
  parameter int unsigned NUM_CH  = 3,
  parameter int unsigned DIV_W   = 16,
  parameter logic [calc_w(CH_BITS, NUM_CH)-1:0] SEED = calc_w(CH_BITS, NUM_CH)'(1)
) (
  input  logic                              pixel_clk,
  input  logic                              rst,
  input  logic                              refresh,
  input  logic [DIV_W-1:0]                  rate,
  input  logic [1:0]                        mode,
  input  logic                              dir,
  output logic [calc_w(CH_BITS, NUM_CH)-1:0] colour,
  output logic                              tick,
  output logic                              wrap
);

  localparam int unsigned W     = calc_w(CH_BITS, NUM_CH);
  localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  mode_e              w_mode;
  logic               w_step;
  logic [W-1:0]       r_pattern;
  logic [PTR_W-1:0]   r_ptr;
  logic [W-1:0]       r_colour;
  logic               r_tick_pend;
  logic               r_wrap_pend;
  logic               r_tick;
  logic               r_wrap;

  logic [W-1:0]       w_pattern_nxt;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic               w_wrap_nxt;
  logic [CH_BITS-1:0] w_field;

  assign w_mode = mode_e'(mode);

  scroll_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .clear     (refresh),
    .enable    (w_mode != MODE_HOLD),
    .rate      (rate),
    .step      (w_step)
  );

  // Selected channel field for round-robin mode
  always_comb begin
    w_field = CH_BITS'(0);
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (r_ptr == PTR_W'(i)) begin
        w_field = r_pattern[i*CH_BITS +: CH_BITS];
      end
    end
  end

  // Next pattern, pointer and wrap flag for a step in the current mode
  always_comb begin
    w_pattern_nxt = r_pattern;
    w_ptr_nxt     = r_ptr;
    w_wrap_nxt    = 1'b0;
    case (w_mode)
      MODE_COUNT: begin
        if (dir) begin
          w_pattern_nxt = r_pattern + W'(1);
          w_wrap_nxt    = &r_pattern;
        end else begin
          w_pattern_nxt = r_pattern - W'(1);
          w_wrap_nxt    = (r_pattern == W'(0));
        end
      end
      MODE_RR: begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
          if (r_ptr == PTR_W'(i)) begin
            w_pattern_nxt[i*CH_BITS +: CH_BITS] =
              dir ? w_field + CH_BITS'(1) : w_field - CH_BITS'(1);
          end
        end
        if (dir) begin
          w_wrap_nxt = (r_ptr == PTR_W'(NUM_CH - 1));
          w_ptr_nxt  = w_wrap_nxt ? PTR_W'(0) : r_ptr + PTR_W'(1);
        end else begin
          w_wrap_nxt = (r_ptr == PTR_W'(0));
          w_ptr_nxt  = w_wrap_nxt ? PTR_W'(NUM_CH - 1) : r_ptr - PTR_W'(1);
        end
      end
      MODE_WALK: begin
        // An all-zero pattern would walk forever as zero, so restart from one
        if (r_pattern == W'(0)) begin
          w_pattern_nxt = W'(1);
        end else if (dir) begin
          w_pattern_nxt = {r_pattern[W-2:0], r_pattern[W-1]};
          w_wrap_nxt    = r_pattern[W-1];
        end else begin
          w_pattern_nxt = {r_pattern[0], r_pattern[W-1:1]};
          w_wrap_nxt    = r_pattern[0];
        end
      end
      default: begin
        w_pattern_nxt = r_pattern;
      end
    endcase
  end

  // Pattern state plus output stage; status strobes are delayed one extra
  // cycle so they line up with the colour word that carries the step.
  always_ff @(posedge pixel_clk) begin
    if (rst || refresh) begin
      r_pattern   <= SEED;
      r_ptr       <= PTR_W'(0);
      r_colour    <= W'(0);
      r_tick_pend <= 1'b0;
      r_wrap_pend <= 1'b0;
      r_tick      <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_colour    <= r_pattern;
      r_tick_pend <= w_step;
      r_wrap_pend <= w_step & w_wrap_nxt;
      r_tick      <= r_tick_pend;
      r_wrap      <= r_wrap_pend;
      if (w_step) begin
        r_pattern <= w_pattern_nxt;
        r_ptr     <= w_ptr_nxt;
      end
    end
  end

  assign colour = r_colour;
  assign tick   = r_tick;
  assign wrap   = r_wrap;

endmodule

// File: doc/scroll_colour_gen.md
Name: scroll_colour_gen

Overview:
Parametrised successor to the single-mode colour scroller used in the VGA pipeline. It generates a scrolling colour word for NUM_CH channels of CH_BITS each. The scroll rate comes from an internal prescaler on pixel_clk, so no separate scroll clock domain is needed. It provides four run-time modes, up/down direction, output blanking during refresh, and tick/wrap status strobes for downstream pattern logic.

Parameters:
CH_BITS, 3, bits per colour channel
NUM_CH, 3, number of channels; total width W = CH_BITS*NUM_CH
DIV_W, 16, prescaler counter width
SEED, 1, pattern value loaded on reset/refresh (W bits, must be nonzero)

Ports:
pixel_clk  in  1  sole clock; all logic on posedge
rst  in  1  synchronous, active-high reset
refresh  in  1  blank output and re-seed pattern while high
rate  in  DIV_W  scroll period minus one, in pixel_clk cycles
mode  in  2  0 binary count, 1 channel round-robin, 2 walking one, 3 hold
dir  in  1  1 up/left, 0 down/right
colour  out  W  registered colour word, channel 0 in LSBs
tick  out  1  one-cycle pulse on each applied scroll step
wrap  out  1  one-cycle pulse when the pattern completes a cycle

Behaviour:
- Reset (rst high at posedge): pattern=SEED, ptr=0, cnt=0, colour=0, tick=0, wrap=0. rst has priority over every other input.
- Prescaler: if cnt >= rate, the step is taken and cnt<=0. Otherwise cnt<=cnt+1. rate=0 gives a step every cycle. Using >= means that if rate is lowered below the current cnt, the step happens on the next cycle.
- refresh high (rst low): pattern<=SEED, ptr<=0, cnt<=0, colour<=0, tick=0, wrap=0.
- refresh low: colour<=pattern, giving 1-cycle latency from pattern register to output. After refresh falls, the first cycle shows SEED, and the first step occurs rate+1 cycles later.
- mode 3 (hold): cnt held, pattern held, tick=0, wrap=0, colour continues to track pattern.
- Step, mode 0: pattern <= pattern+1 (dir=1) or pattern-1 (dir=0), modulo 2^W. wrap=1 on all-ones->0 (up) or 0->all-ones (down).
- Step, mode 1: only field ptr (bits ptr*CH_BITS +: CH_BITS) changes, by ±1 modulo 2^CH_BITS. Other fields are unchanged. ptr then advances: NUM_CH-1 -> 0 when up, 0 -> NUM_CH-1 when down. wrap=1 when ptr wraps.
- Step, mode 2: rotate left by 1 (dir=1) or right by 1 (dir=0). If pattern==0 at the step, load 1 instead. wrap=1 when bit W-1 rotates into bit 0 (left) or bit 0 rotates into bit W-1 (right).
- tick=1 in the cycle after every step in modes 0-2. tick and wrap are registered and aligned with the colour update of that step.
- Mode/dir changes: sampled only at step time. The pattern is never reloaded on a mode change. ptr is kept across modes and used only by mode 1.
- refresh and a step due in the same cycle: refresh wins and no step is taken.
- Widths: all arithmetic truncated to field width; no saturation anywhere.

Decomposition:
- Package scroll_pkg holds the mode encodings (MODE_COUNT=0, MODE_RR=1, MODE_WALK=2, MODE_HOLD=3) and a function returning W from CH_BITS/NUM_CH.
- Sub-module scroll_prescaler (pixel_clk, rst, clear, enable, rate -> step) holds the cnt logic. The top holds the pattern, ptr, mode datapath and output registers.

Test Plan:
- Reset then rate=0, mode=0, dir=1, refresh=0 -> colour 0 for 1 cycle, then 1, 2, 3, ... one per cycle; at 0x1FF->0x000, wrap=1 for exactly that cycle.
- rate=3, mode=1, dir=1 from SEED=1 -> tick every 4 cycles; colour sequence 0x001, 0x002, 0x00A, 0x04A, 0x04B; wrap on the step from 0x00A to 0x04A (ptr 2->0).
- mode=2, dir=0, rate=0 from SEED=1 -> colour 0x100 with wrap=1, then 0x080, 0x040, ... 0x001, 0x100 with wrap=1.
- refresh pulsed high for 5 cycles mid-run at rate=0, mode=0 -> colour 0 throughout, tick=0; after the fall, colour 1, then 2 on the next cycle.
- mode=3 for 10 cycles, then mode=0 with rate=2 -> colour frozen and no tick during hold; the next step occurs 3 cycles after resume, with cnt continuing from its held value.
- rate switched from 100 to 2 while cnt=50 -> step on the next cycle, then steps every 3 cycles; rst asserted mid-step returns all outputs to 0 with pattern=SEED.
